// File: rtl/e203_exu_branchslv_mc_if.sv
// Commit-slot and IFU flush bundle for the multi-channel branch resolver.
// master = commit stage / IFU side, slave = resolver.
interface e203_exu_branchslv_mc_if #(
    parameter int NCH  = 2,
    parameter int PC_W = 32
);
    logic [NCH-1:0]      cmt_i_valid;
    logic [NCH-1:0]      cmt_i_ready;
    logic [NCH-1:0]      cmt_i_rv32;
    logic [NCH-1:0]      cmt_i_bjp;
    logic [NCH-1:0]      cmt_i_bjp_prdt;
    logic [NCH-1:0]      cmt_i_bjp_rslv;
    logic [NCH-1:0]      cmt_i_fencei;
    logic [NCH-1:0]      cmt_i_mret;
    logic [NCH-1:0]      cmt_i_dret;
    logic [NCH*PC_W-1:0] cmt_i_pc;
    logic [NCH*PC_W-1:0] cmt_i_imm;
    logic                brchmis_flush_req;
    logic                brchmis_flush_ack;
    logic [PC_W-1:0]     brchmis_flush_pc;

    modport master (
        output cmt_i_valid, cmt_i_rv32, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
               cmt_i_fencei, cmt_i_mret, cmt_i_dret, cmt_i_pc, cmt_i_imm,
               brchmis_flush_ack,
        input  cmt_i_ready, brchmis_flush_req, brchmis_flush_pc
    );

    modport slave (
        input  cmt_i_valid, cmt_i_rv32, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
               cmt_i_fencei, cmt_i_mret, cmt_i_dret, cmt_i_pc, cmt_i_imm,
               brchmis_flush_ack,
        output cmt_i_ready, brchmis_flush_req, brchmis_flush_pc
    );
endinterface

// File: rtl/e203_exu_branchslv_mc.sv
// Oldest-flush picker over NCH commit slots; E203_BRSLV_PERF_EN adds saturating BJP perf counters.
// Latency: need in cycle N -> registered flush_pc and req in N+1; slot retires on the req&ack cycle.
// Backpressure: flush req held until ack; selected and younger slots stall (ready=0) meanwhile.
module e203_exu_branchslv_mc #(
    parameter int NCH   = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_exu_branchslv_mc_if.slave cmt,
    input  logic [PC_W-1:0]      csr_epc_r,
    input  logic [PC_W-1:0]      csr_dpc_r,
    input  logic                 nonalu_excpirq_flush_req_raw,
    output logic                 cmt_mret_ena,
    output logic                 cmt_dret_ena,
    output logic                 cmt_fencei_ena,
    input  logic                 perf_clr,
    output logic [CNT_W-1:0]     perf_bjp_cnt,
    output logic [CNT_W-1:0]     perf_mis_cnt
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t             state, state_nxt;
    logic               nonalu;
    logic [NCH-1:0]     need, is_br;
    logic               any_need;
    logic [SEL_W-1:0]   sel, sel_q;
    logic               capture, hs_flush;

    logic [PC_W-1:0]    s_pc, s_imm, tgt;
    logic               s_rv32, s_bjp, s_prdt, s_fencei, s_mret, s_dret;

    logic [PC_W-1:0]    flush_pc_q;
    logic               mret_q, dret_q, fencei_q;

    assign nonalu = nonalu_excpirq_flush_req_raw;

    always_comb begin
        need     = '0;
        is_br    = '0;
        sel      = '0;
        for (int i = 0; i < NCH; i++) begin
            is_br[i] = cmt.cmt_i_bjp[i] | cmt.cmt_i_fencei[i] | cmt.cmt_i_mret[i] | cmt.cmt_i_dret[i];
            need[i]  = cmt.cmt_i_valid[i] &
                       ((cmt.cmt_i_bjp[i] & (cmt.cmt_i_bjp_prdt[i] ^ cmt.cmt_i_bjp_rslv[i])) |
                        cmt.cmt_i_fencei[i] | cmt.cmt_i_mret[i] | cmt.cmt_i_dret[i]);
        end
        // Descending scan so the lowest (oldest) needing slot wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (need[i]) begin
                sel = SEL_W'(i);
            end
        end
        any_need = |need;
    end

    always_comb begin
        s_pc     = '0;
        s_imm    = '0;
        s_rv32   = 1'b0;
        s_bjp    = 1'b0;
        s_prdt   = 1'b0;
        s_fencei = 1'b0;
        s_mret   = 1'b0;
        s_dret   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (SEL_W'(i) == sel) begin
                s_pc     = cmt.cmt_i_pc[i*PC_W +: PC_W];
                s_imm    = cmt.cmt_i_imm[i*PC_W +: PC_W];
                s_rv32   = cmt.cmt_i_rv32[i];
                s_bjp    = cmt.cmt_i_bjp[i];
                s_prdt   = cmt.cmt_i_bjp_prdt[i];
                s_fencei = cmt.cmt_i_fencei[i];
                s_mret   = cmt.cmt_i_mret[i];
                s_dret   = cmt.cmt_i_dret[i];
            end
        end
        if (s_dret) begin
            tgt = csr_dpc_r;
        end else if (s_mret) begin
            tgt = csr_epc_r;
        end else if (s_fencei | (s_bjp & s_prdt)) begin
            tgt = s_pc + (s_rv32 ? PC_W'(4) : PC_W'(2));
        end else begin
            tgt = s_pc + s_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt                 = state;
        capture                   = 1'b0;
        hs_flush                  = 1'b0;
        cmt.brchmis_flush_req     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_need & ~nonalu) begin
                    capture   = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cmt.brchmis_flush_req = ~nonalu;
                // An exception/irq flush supersedes ours; the latched entry is simply dropped.
                if (nonalu) begin
                    state_nxt = ST_IDLE;
                end else if (cmt.brchmis_flush_ack) begin
                    hs_flush  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            flush_pc_q <= '0;
            mret_q     <= 1'b0;
            dret_q     <= 1'b0;
            fencei_q   <= 1'b0;
        end else if (capture) begin
            sel_q      <= sel;
            flush_pc_q <= tgt;
            dret_q     <= s_dret;
            mret_q     <= s_mret & ~s_dret;
            fencei_q   <= s_fencei & ~s_mret & ~s_dret;
        end
    end

    assign cmt.brchmis_flush_pc = flush_pc_q;
    assign cmt_mret_ena         = hs_flush & mret_q;
    assign cmt_dret_ena         = hs_flush & dret_q;
    assign cmt_fencei_ena       = hs_flush & fencei_q;

    // Older non-flushing slots retire freely in IDLE; branches among them hold off under an exception flush.
    always_comb begin
        cmt.cmt_i_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state == ST_IDLE) begin
                if (!any_need || (SEL_W'(i) < sel)) begin
                    cmt.cmt_i_ready[i] = ~is_br[i] | ~nonalu;
                end
            end else if (hs_flush && (SEL_W'(i) == sel_q)) begin
                cmt.cmt_i_ready[i] = 1'b1;
            end
        end
    end

`ifdef E203_BRSLV_PERF_EN
    logic [NCH-1:0] hs;
    logic [2:0]     inc_bjp, inc_mis;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign hs = cmt.cmt_i_valid & cmt.cmt_i_ready;

    always_comb begin
        inc_bjp = '0;
        inc_mis = '0;
        for (int i = 0; i < NCH; i++) begin
            if (hs[i] & cmt.cmt_i_bjp[i]) begin
                if (cmt.cmt_i_bjp_prdt[i] ^ cmt.cmt_i_bjp_rslv[i]) begin
                    inc_mis = inc_mis + 3'd1;
                end else begin
                    inc_bjp = inc_bjp + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst | perf_clr) begin
            perf_bjp_cnt <= '0;
            perf_mis_cnt <= '0;
        end else begin
            perf_bjp_cnt <= sat_add(perf_bjp_cnt, inc_bjp);
            perf_mis_cnt <= sat_add(perf_mis_cnt, inc_mis);
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_bjp_cnt    = '0;
    assign perf_mis_cnt    = '0;
`endif

endmodule

// File: tb/tb_e203_exu_branchslv_mc.sv
// Directed bench for e203_exu_branchslv_mc: flush capture table plus multi-cycle sequences.
module tb_e203_exu_branchslv_mc;
    localparam int NCH   = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
`ifdef E203_BRSLV_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] EPC = 32'h0000_8000;
    localparam logic [31:0] DPC = 32'h0000_3000;

    logic clk = 1'b0;
    logic rst;
    logic [PC_W-1:0]  csr_epc_r, csr_dpc_r;
    logic             nonalu;
    logic             mret_ena, dret_ena, fencei_ena;
    logic             perf_clr;
    logic [CNT_W-1:0] perf_bjp_cnt, perf_mis_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int mret_pulses = 0;

    always #5 clk = ~clk;

    e203_exu_branchslv_mc_if #(.NCH(NCH), .PC_W(PC_W)) bif ();

    e203_exu_branchslv_mc #(.NCH(NCH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .cmt                          (bif),
        .csr_epc_r                    (csr_epc_r),
        .csr_dpc_r                    (csr_dpc_r),
        .nonalu_excpirq_flush_req_raw (nonalu),
        .cmt_mret_ena                 (mret_ena),
        .cmt_dret_ena                 (dret_ena),
        .cmt_fencei_ena               (fencei_ena),
        .perf_clr                     (perf_clr),
        .perf_bjp_cnt                 (perf_bjp_cnt),
        .perf_mis_cnt                 (perf_mis_cnt)
    );

    always @(negedge clk) if (mret_ena) mret_pulses++;

    typedef struct packed {
        logic [1:0]  valid, bjp, prdt, rslv, fencei, mret, dret, rv32;
        logic [31:0] pc0, pc1, imm0, imm1;
        logic [1:0]  exp_rdy0;
        int          exp_sel;
        logic [31:0] exp_pc;
        logic [2:0]  exp_ena;   // {mret, dret, fencei}
        int          ack_dly;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_slots();
        bif.cmt_i_valid    = '0;
        bif.cmt_i_bjp      = '0;
        bif.cmt_i_bjp_prdt = '0;
        bif.cmt_i_bjp_rslv = '0;
        bif.cmt_i_fencei   = '0;
        bif.cmt_i_mret     = '0;
        bif.cmt_i_dret     = '0;
        bif.cmt_i_rv32     = '0;
        bif.cmt_i_pc       = '0;
        bif.cmt_i_imm      = '0;
    endtask

    task automatic apply(input vec_t v);
        bif.cmt_i_valid    = v.valid;
        bif.cmt_i_bjp      = v.bjp;
        bif.cmt_i_bjp_prdt = v.prdt;
        bif.cmt_i_bjp_rslv = v.rslv;
        bif.cmt_i_fencei   = v.fencei;
        bif.cmt_i_mret     = v.mret;
        bif.cmt_i_dret     = v.dret;
        bif.cmt_i_rv32     = v.rv32;
        bif.cmt_i_pc       = {v.pc1, v.pc0};
        bif.cmt_i_imm      = {v.imm1, v.imm0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enas();
        return {29'd0, mret_ena, dret_ena, fencei_ena};
    endfunction

    initial begin
        vt[0] = '{valid:2'b01, bjp:2'b01, prdt:2'b01, rv32:2'b01, pc0:32'h100,
                  exp_rdy0:2'b00, exp_sel:0, exp_pc:32'h104, exp_ena:3'b000, ack_dly:3, default:'0};
        vt[1] = '{valid:2'b11, bjp:2'b10, rslv:2'b10, rv32:2'b11, pc0:32'h1FC, pc1:32'h200,
                  imm1:32'hFFFF_FFF0, exp_rdy0:2'b01, exp_sel:1, exp_pc:32'h1F0, exp_ena:3'b000,
                  ack_dly:1, default:'0};
        vt[2] = '{valid:2'b11, dret:2'b01, bjp:2'b10, prdt:2'b10, pc0:32'h50, pc1:32'h54,
                  exp_rdy0:2'b00, exp_sel:0, exp_pc:DPC, exp_ena:3'b010, ack_dly:0, default:'0};
        vt[3] = '{valid:2'b11, bjp:2'b01, prdt:2'b01, rslv:2'b01, fencei:2'b10, pc1:32'h400,
                  exp_rdy0:2'b01, exp_sel:1, exp_pc:32'h402, exp_ena:3'b001, ack_dly:2, default:'0};
        vt[4] = '{valid:2'b01, bjp:2'b01, prdt:2'b01, pc0:32'hFFFF_FFFE,
                  exp_rdy0:2'b00, exp_sel:0, exp_pc:32'h0, exp_ena:3'b000, ack_dly:0, default:'0};
        vt[5] = '{valid:2'b10, fencei:2'b01, mret:2'b10, pc1:32'h900,
                  exp_rdy0:2'b01, exp_sel:1, exp_pc:EPC, exp_ena:3'b100, ack_dly:1, default:'0};

        rst = 1'b1; nonalu = 1'b0; perf_clr = 1'b0;
        csr_epc_r = EPC; csr_dpc_r = DPC;
        bif.brchmis_flush_ack = 1'b0;
        clear_slots();
        step(); step();
        rst = 1'b0;

        @(negedge clk);
        chk("reset req", 32'(bif.brchmis_flush_req), 32'd0);
        chk("reset flush_pc", bif.brchmis_flush_pc, 32'd0);
        chk("reset ena", enas(), 32'd0);
        chk("reset perf_bjp", 32'(perf_bjp_cnt), 32'd0);
        chk("reset ready", 32'(bif.cmt_i_ready), 32'd3);
        step();

        for (int k = 0; k < 6; k++) begin
            apply(vt[k]);
            @(negedge clk);
            chk($sformatf("v%0d ready capture", k), 32'(bif.cmt_i_ready), 32'(vt[k].exp_rdy0));
            chk($sformatf("v%0d req idle", k), 32'(bif.brchmis_flush_req), 32'd0);
            step();
            for (int i = 0; i < NCH; i++) if (i < vt[k].exp_sel) bif.cmt_i_valid[i] = 1'b0;
            for (int d = 0; d < vt[k].ack_dly; d++) begin
                @(negedge clk);
                chk($sformatf("v%0d req wait%0d", k, d), 32'(bif.brchmis_flush_req), 32'd1);
                chk($sformatf("v%0d pc wait%0d", k, d), bif.brchmis_flush_pc, vt[k].exp_pc);
                chk($sformatf("v%0d ready wait%0d", k, d), 32'(bif.cmt_i_ready), 32'd0);
                step();
            end
            bif.brchmis_flush_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d req ack", k), 32'(bif.brchmis_flush_req), 32'd1);
            chk($sformatf("v%0d flush_pc", k), bif.brchmis_flush_pc, vt[k].exp_pc);
            chk($sformatf("v%0d ready ack", k), 32'(bif.cmt_i_ready), 32'(2'b01 << vt[k].exp_sel));
            chk($sformatf("v%0d ena", k), enas(), 32'(vt[k].exp_ena));
            step();
            bif.brchmis_flush_ack = 1'b0;
            clear_slots();
            @(negedge clk);
            chk($sformatf("v%0d req after", k), 32'(bif.brchmis_flush_req), 32'd0);
            chk($sformatf("v%0d ena after", k), enas(), 32'd0);
            step();
        end

        // mret in slot 0 then fencei in slot 1: two back-to-back flushes
        mret_pulses = 0;
        bif.cmt_i_valid = 2'b11; bif.cmt_i_mret = 2'b01; bif.cmt_i_fencei = 2'b10;
        bif.cmt_i_rv32 = 2'b10; bif.cmt_i_pc = {32'h500, 32'h10};
        @(negedge clk);
        chk("t3 ready capture", 32'(bif.cmt_i_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t3 pc mret", bif.brchmis_flush_pc, EPC);
        chk("t3 ready hold", 32'(bif.cmt_i_ready), 32'd0);
        step();
        bif.brchmis_flush_ack = 1'b1;
        @(negedge clk);
        chk("t3 ready mret", 32'(bif.cmt_i_ready), 32'd1);
        chk("t3 ena mret", enas(), 32'd4);
        step();
        bif.brchmis_flush_ack = 1'b0;
        bif.cmt_i_valid[0] = 1'b0; bif.cmt_i_mret[0] = 1'b0;
        @(negedge clk);
        chk("t3 req gap", 32'(bif.brchmis_flush_req), 32'd0);
        step();
        @(negedge clk);
        chk("t3 req fencei", 32'(bif.brchmis_flush_req), 32'd1);
        chk("t3 pc fencei", bif.brchmis_flush_pc, 32'h504);
        step();
        bif.brchmis_flush_ack = 1'b1;
        @(negedge clk);
        chk("t3 ready fencei", 32'(bif.cmt_i_ready), 32'd2);
        chk("t3 ena fencei", enas(), 32'd1);
        step();
        bif.brchmis_flush_ack = 1'b0;
        clear_slots();
        @(negedge clk);
        chk("t3 mret pulses", 32'(mret_pulses), 32'd1);
        step();

        // exception flush overriding a pending branch flush
        bif.cmt_i_valid = 2'b01; bif.cmt_i_bjp = 2'b01; bif.cmt_i_bjp_rslv = 2'b01;
        bif.cmt_i_pc = {32'h0, 32'h600}; bif.cmt_i_imm = {32'h0, 32'h20};
        step();
        @(negedge clk);
        chk("t4 req", 32'(bif.brchmis_flush_req), 32'd1);
        chk("t4 pc", bif.brchmis_flush_pc, 32'h620);
        step();
        nonalu = 1'b1; bif.brchmis_flush_ack = 1'b1;
        @(negedge clk);
        chk("t4 req nonalu", 32'(bif.brchmis_flush_req), 32'd0);
        chk("t4 ready nonalu", 32'(bif.cmt_i_ready), 32'd0);
        chk("t4 ena nonalu", enas(), 32'd0);
        step();
        bif.brchmis_flush_ack = 1'b0;
        @(negedge clk);
        chk("t4 req idle", 32'(bif.brchmis_flush_req), 32'd0);
        chk("t4 ready idle", 32'(bif.cmt_i_ready), 32'd0);
        step();
        clear_slots();
        bif.cmt_i_valid = 2'b11; bif.cmt_i_bjp = 2'b10; bif.cmt_i_bjp_prdt = 2'b10;
        bif.cmt_i_bjp_rslv = 2'b10;
        @(negedge clk);
        chk("t4 ready alu vs br", 32'(bif.cmt_i_ready), 32'd1);
        step();
        nonalu = 1'b0;
        clear_slots();
        @(negedge clk);
        chk("t4 req dropped", 32'(bif.brchmis_flush_req), 32'd0);
        step();

        // perf counters: clear, count, saturate, clear beats increment
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        @(negedge clk);
        chk("t5 bjp clr", 32'(perf_bjp_cnt), 32'd0);
        bif.cmt_i_valid = 2'b01; bif.cmt_i_bjp = 2'b01;
        bif.cmt_i_bjp_prdt = 2'b01; bif.cmt_i_bjp_rslv = 2'b01;
        step();
        step(); step();
        @(negedge clk);
        chk("t5 bjp 3", 32'(perf_bjp_cnt), PERF ? 32'd3 : 32'd0);
        repeat (14) step();
        @(negedge clk);
        chk("t5 bjp sat", 32'(perf_bjp_cnt), PERF ? 32'hF : 32'd0);
        chk("t5 mis", 32'(perf_mis_cnt), 32'd0);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        clear_slots();
        @(negedge clk);
        chk("t5 clr wins", 32'(perf_bjp_cnt), 32'd0);
        step();

        // reset while a flush is outstanding
        bif.cmt_i_valid = 2'b01; bif.cmt_i_bjp = 2'b01; bif.cmt_i_bjp_rslv = 2'b01;
        bif.cmt_i_pc = {32'h0, 32'h700}; bif.cmt_i_imm = {32'h0, 32'h8};
        step();
        @(negedge clk);
        chk("t6 pc pre", bif.brchmis_flush_pc, 32'h708);
        step();
        rst = 1'b1;
        clear_slots();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6 req rst", 32'(bif.brchmis_flush_req), 32'd0);
        chk("t6 pc rst", bif.brchmis_flush_pc, 32'd0);
        chk("t6 ena rst", enas(), 32'd0);
        chk("t6 mis rst", 32'(perf_mis_cnt), 32'd0);
        step();
        bif.cmt_i_valid = 2'b01; bif.cmt_i_fencei = 2'b01; bif.cmt_i_rv32 = 2'b01;
        bif.cmt_i_pc = {32'h0, 32'h10};
        step();
        bif.brchmis_flush_ack = 1'b1;
        @(negedge clk);
        chk("t6 req new", 32'(bif.brchmis_flush_req), 32'd1);
        chk("t6 pc new", bif.brchmis_flush_pc, 32'h14);
        chk("t6 ena new", enas(), 32'd1);
        chk("t6 ready new", 32'(bif.cmt_i_ready), 32'd1);
        step();
        bif.brchmis_flush_ack = 1'b0;
        clear_slots();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
